// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver with ready/valid output and sticky error flags
module uart_rx #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 baud_clk,
    input  logic                 nrst,
    input  logic                 sin,
    input  logic                 rx_ready,
    input  logic                 err_clr,
    output logic [DATA_BITS-1:0] dout,
    output logic                 rx_valid,
    output logic                 busy_rx,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int IDX_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 sync1, s_sin;
    logic                 load, set_ovr, set_ferr;

    always_ff @(posedge baud_clk) begin
        if (nrst) begin
            sync1 <= 1'b1;
            s_sin <= 1'b1;
        end else begin
            sync1 <= sin;
            s_sin <= sync1;
        end
    end

    always_ff @(posedge baud_clk) begin
        if (nrst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        load     = 1'b0;
        set_ovr  = 1'b0;
        set_ferr = 1'b0;
        case (state_q)
            IDLE: begin
                if (!s_sin) state_d = START;
            end
            START: begin
                // mid-start re-check rejects short glitches
                if (cnt_q == CNT_HALF) begin
                    if (!s_sin) begin
                        state_d = DATA;
                        idx_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    shift_d = {s_sin, shift_q[DATA_BITS-1:1]};
                    idx_d   = idx_q + IDX_W'(1);
                    if (idx_q == IDX_LAST) state_d = STOP;
                end
            end
            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    if (s_sin) begin
                        if (!rx_valid || rx_ready) load = 1'b1;
                        else                       set_ovr = 1'b1;
                        state_d = IDLE;
                    end else begin
                        set_ferr = 1'b1;
                        state_d  = BREAK;
                    end
                end
            end
            BREAK: begin
                if (s_sin) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (state_d != state_q)   cnt_d = '0;
        else if (cnt_q == CNT_LAST) cnt_d = '0;
        else                        cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge baud_clk) begin
        if (nrst) begin
            dout      <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (load) begin
                dout     <= shift_q;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            frame_err <= set_ferr | (frame_err & ~err_clr);
            overrun   <= set_ovr  | (overrun   & ~err_clr);
        end
    end

    assign busy_rx = (state_q != IDLE);

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter OVERSAMPLE, default 16: number of baud_clk cycles per serial bit; even, at least 4.
REQ-002 Parameter DATA_BITS, default 8: data bits per frame, from 5 to 8.
REQ-003 Port baud_clk, input, 1: sampling clock running at OVERSAMPLE x bit rate; all logic on its rising edge.
REQ-004 Port nrst, input, 1: reset, synchronous, active-high.
REQ-005 Port sin, input, 1: asynchronous serial line; idles high; frame is start(0), data LSB-first, stop(1).
REQ-006 Port rx_ready, input, 1: consumer can accept dout this cycle.
REQ-007 Port err_clr, input, 1: one-cycle pulse that clears the sticky error flags.
REQ-008 Port dout, output, DATA_BITS: most recently received good word.
REQ-009 Port rx_valid, output, 1: dout holds an unconsumed word.
REQ-010 Port busy_rx, output, 1: a frame is in progress (state not IDLE).
REQ-011 Port frame_err, output, 1: sticky; a stop bit was sampled low.
REQ-012 Port overrun, output, 1: sticky; a good word was dropped because dout was still occupied.

Function
REQ-013 sin shall pass through a 2-flop synchronizer; both flops reset to 1; all decisions use the second flop (s_sin).
REQ-014 The FSM shall have exactly five states: IDLE, START, DATA, STOP, BREAK.
REQ-015 A tick counter shall count 0..OVERSAMPLE-1, wrap to 0, and be cleared on every state entry.
REQ-016 IDLE: on s_sin==0, go to START with the counter at 0.
REQ-017 START: at counter==OVERSAMPLE/2-1, go to DATA if s_sin==0; otherwise treat it as a glitch and go to IDLE with no flag change.
REQ-018 DATA: at each counter==OVERSAMPLE-1, sample s_sin and shift it into the MSB of the shift register (LSB-first assembly).
REQ-019 DATA: after DATA_BITS samples, go to STOP; the bit index shall be ceil(log2(DATA_BITS+1)) bits wide.
REQ-020 STOP: at counter==OVERSAMPLE-1, sample s_sin.
REQ-021 STOP sample 1, dout empty: load dout, assert rx_valid the following cycle, go to IDLE.
REQ-022 STOP sample 1, rx_valid=1 and rx_ready=0: discard the word, set overrun, leave dout unchanged, go to IDLE.
REQ-023 STOP sample 0: discard the word, set frame_err, go to BREAK.
REQ-024 BREAK: stay until s_sin==1, then go to IDLE; a stuck-low line shall yield exactly one frame_err.
REQ-025 Handshake: rx_valid&&rx_ready consumes the word; rx_valid drops the next cycle unless a new word loads at the same edge.
REQ-026 A consume and a good-stop load on the same edge: load the new word, keep rx_valid=1, do not set overrun.
REQ-027 dout shall remain stable while rx_valid=1.
REQ-028 err_clr clears frame_err and overrun; if a set event occurs on the same edge, the set wins.
REQ-029 Latency: from the first low s_sin to rx_valid=1 shall be OVERSAMPLE/2 + (DATA_BITS+1)*OVERSAMPLE + 1 cycles.
REQ-030 busy_rx shall be 1 in START, DATA, STOP and BREAK, and 0 in IDLE.

Reset
REQ-031 While nrst=1 at a rising edge: state=IDLE, counter=0, bit index=0, shift register=0, dout=0, rx_valid=0, frame_err=0, overrun=0, synchronizer flops=1.
REQ-032 A reset asserted mid-frame shall abort the frame with no flag set; reception restarts at the next falling edge after nrst=0.

Verification (OVERSAMPLE=16, DATA_BITS=8)
REQ-033 Frame 0xA5 with rx_ready=1 -> dout=0xA5, rx_valid high exactly 1 cycle, frame_err=0, latency 153 cycles.
REQ-034 sin low for 4 cycles then high -> busy_rx high for at most 9 cycles, rx_valid=0, no flags set.
REQ-035 Frame 0x3C with stop=0, then line low 40 cycles -> frame_err=1 (once), rx_valid=0; err_clr pulse -> frame_err=0.
REQ-036 Frames 0x11 then 0x22 back-to-back, rx_ready=0 -> dout=0x11, rx_valid=1, overrun=1.
REQ-037 Frames 0x55 and 0xAA, rx_ready=1 exactly at the load edge of 0xAA -> dout=0xAA, rx_valid stays 1, overrun=0.
REQ-038 nrst=1 during DATA of frame 0xFF, then frame 0x81 -> no flag set, dout=0x81.
